// File: rtl/pipe_perf_monitor_pkg.sv
// Shared definitions for the pipeline run monitor: FSM encoding and done-cause codes.
package pipe_perf_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [31:0] END_OF_PROGRAM_WORD = 32'h0;
  localparam logic        DONE_CAUSE_EOP      = 1'b0;
  localparam logic        DONE_CAUSE_LIMIT    = 1'b1;

endpackage

// File: rtl/pipe_perf_monitor_sat_counter.sv
// Event counter with synchronous clear that sticks at all-ones instead of wrapping.
module pipe_perf_monitor_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (en_i && inc_i && (count_q != '1)) begin
      count_q <= count_q + One;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Run monitor behind the pipelined core: counts cycles, load-use stalls, flushes and
// retirements, and raises done once the pipeline drains after the end-of-program fetch.
module pipe_perf_monitor
  import pipe_perf_monitor_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             wb_valid_i,
  input  logic [31:0]      if_instr_i,
  input  logic [31:0]      pc_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [31:0]      end_pc_o,
  output logic             running_o,
  output logic             done_o,
  output logic             done_cause_o
);

  // A limit the cycle counter can never reach is treated as disabled.
  localparam logic [63:0]      CntMax   = (64'd1 << CNT_W) - 64'd1;
  localparam bit               LimitEn  = (MAX_CYCLES != 0) && (64'(MAX_CYCLES) <= CntMax);
  localparam logic [CNT_W-1:0] LimitM1  = CNT_W'(MAX_CYCLES - 1);

  state_e      state_q;
  logic [31:0] drain_q;
  logic [31:0] end_pc_q;
  logic        done_cause_q;
  logic        running_q;
  logic        done_q;

  logic counting;
  logic eop_fetch;
  logic limit_hit;

  assign counting  = (state_q == StRun) || (state_q == StDrain);
  assign eop_fetch = (if_instr_i == END_OF_PROGRAM_WORD);
  // This cycle's increment lands the cycle counter exactly on the limit.
  assign limit_hit = LimitEn && counting && (cycle_cnt_o == LimitM1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      drain_q      <= '0;
      end_pc_q     <= '0;
      done_cause_q <= DONE_CAUSE_EOP;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (eop_fetch) begin
            end_pc_q <= pc_i;
            drain_q  <= DRAIN_CYCLES;
          end
          if (limit_hit) begin
            state_q      <= StDone;
            done_cause_q <= DONE_CAUSE_LIMIT;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
          end else if (eop_fetch && (DRAIN_CYCLES == 0)) begin
            state_q      <= StDone;
            done_cause_q <= DONE_CAUSE_EOP;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
          end else if (eop_fetch) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          drain_q <= drain_q - 32'd1;
          if (limit_hit) begin
            state_q      <= StDone;
            done_cause_q <= DONE_CAUSE_LIMIT;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
          end else if (drain_q == 32'd1) begin
            state_q      <= StDone;
            done_cause_q <= DONE_CAUSE_EOP;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        StDone: begin
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  pipe_perf_monitor_sat_counter #(.Width(CNT_W)) u_cycle_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (counting),
    .inc_i   (1'b1),
    .count_o (cycle_cnt_o)
  );

  pipe_perf_monitor_sat_counter #(.Width(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (counting),
    .inc_i   (stall_i & ~branch_i),
    .count_o (stall_cnt_o)
  );

  pipe_perf_monitor_sat_counter #(.Width(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (counting),
    .inc_i   (flush_i),
    .count_o (flush_cnt_o)
  );

  pipe_perf_monitor_sat_counter #(.Width(CNT_W)) u_retire_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (counting),
    .inc_i   (wb_valid_i),
    .count_o (retire_cnt_o)
  );

  assign end_pc_o     = end_pc_q;
  assign running_o    = running_q;
  assign done_o       = done_q;
  assign done_cause_o = done_cause_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: default, 8-cycle-limit and 4-bit saturating instances.
module tb_pipe_perf_monitor;

  localparam logic [31:0] NZ = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, start, stall, branch, flush, wbv;
  logic [31:0] instr, pc;

  logic [31:0] a_cyc, a_stl, a_fls, a_ret, a_epc;
  logic        a_run, a_done, a_cause;
  logic [31:0] b_cyc, b_stl, b_fls, b_ret, b_epc;
  logic        b_run, b_done, b_cause;
  logic [3:0]  c_cyc, c_stl, c_fls, c_ret;
  logic [31:0] c_epc;
  logic        c_run, c_done, c_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.CNT_W(32), .DRAIN_CYCLES(4), .MAX_CYCLES(64)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .wb_valid_i(wbv), .if_instr_i(instr), .pc_i(pc),
    .cycle_cnt_o(a_cyc), .stall_cnt_o(a_stl), .flush_cnt_o(a_fls), .retire_cnt_o(a_ret),
    .end_pc_o(a_epc), .running_o(a_run), .done_o(a_done), .done_cause_o(a_cause)
  );

  pipe_perf_monitor #(.CNT_W(32), .DRAIN_CYCLES(4), .MAX_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .wb_valid_i(wbv), .if_instr_i(instr), .pc_i(pc),
    .cycle_cnt_o(b_cyc), .stall_cnt_o(b_stl), .flush_cnt_o(b_fls), .retire_cnt_o(b_ret),
    .end_pc_o(b_epc), .running_o(b_run), .done_o(b_done), .done_cause_o(b_cause)
  );

  pipe_perf_monitor #(.CNT_W(4), .DRAIN_CYCLES(4), .MAX_CYCLES(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .wb_valid_i(wbv), .if_instr_i(instr), .pc_i(pc),
    .cycle_cnt_o(c_cyc), .stall_cnt_o(c_stl), .flush_cnt_o(c_fls), .retire_cnt_o(c_ret),
    .end_pc_o(c_epc), .running_o(c_run), .done_o(c_done), .done_cause_o(c_cause)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fls;
    logic [31:0] ret;
    logic [31:0] epc;
    logic        run;
    logic        done;
    logic        cause;
  } exp_t;

  typedef struct packed {
    logic        start;
    logic        stall;
    logic        branch;
    logic        flush;
    logic        wbv;
    logic [31:0] instr;
    logic [31:0] pc;
    exp_t        exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  function automatic vec_t mk(input logic s, st, br, fl, wb, input logic [31:0] ins, p,
                              input int unsigned c, sc, fc, rc, ep,
                              input logic rn, dn, cs);
    vec_t v;
    v.start = s;   v.stall = st;  v.branch = br; v.flush = fl; v.wbv = wb;
    v.instr = ins; v.pc = p;
    v.exp.cyc = c; v.exp.stl = sc; v.exp.fls = fc; v.exp.ret = rc; v.exp.epc = ep;
    v.exp.run = rn; v.exp.done = dn; v.exp.cause = cs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, st, br, fl, wb, input logic [31:0] ins, p);
    start = s; stall = st; branch = br; flush = fl; wbv = wb; instr = ins; pc = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NZ, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_a(input string tag, input exp_t e);
    chk({tag, " cycle"},  64'(a_cyc),   64'(e.cyc));
    chk({tag, " stall"},  64'(a_stl),   64'(e.stl));
    chk({tag, " flush"},  64'(a_fls),   64'(e.fls));
    chk({tag, " retire"}, 64'(a_ret),   64'(e.ret));
    chk({tag, " end_pc"}, 64'(a_epc),   64'(e.epc));
    chk({tag, " run"},    64'(a_run),   64'(e.run));
    chk({tag, " done"},   64'(a_done),  64'(e.done));
    chk({tag, " cause"},  64'(a_cause), 64'(e.cause));
  endtask

  initial begin
    exp_t e;
    //              st br fl wb instr pc       cyc st fl rt epc run done cause
    vecs[0]  = mk(0, 1, 0, 1, 1, NZ,   32'd0,  0,  0, 0, 0, 0,  0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, NZ,   32'd0,  0,  0, 0, 0, 0,  1, 0, 0);
    vecs[2]  = mk(0, 1, 1, 0, 0, NZ,   32'd0,  1,  0, 0, 0, 0,  1, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 0, NZ,   32'd4,  2,  0, 0, 0, 0,  1, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 0, NZ,   32'd8,  3,  1, 0, 0, 0,  1, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 0, NZ,   32'd12, 4,  2, 0, 0, 0,  1, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, NZ,   32'd16, 5,  3, 0, 0, 0,  1, 0, 0);
    vecs[7]  = mk(0, 1, 0, 1, 1, NZ,   32'd20, 6,  4, 1, 1, 0,  1, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 1, NZ,   32'd24, 7,  4, 1, 2, 0,  1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1, NZ,   32'd28, 8,  4, 1, 3, 0,  1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, NZ,   32'd32, 9,  4, 1, 4, 0,  1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, NZ,   32'd36, 10, 4, 1, 5, 0,  1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 32'd0, 32'd40, 11, 4, 1, 6, 40, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 32'd0, 32'd44, 12, 4, 1, 6, 40, 1, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 0, NZ,   32'd48, 13, 4, 2, 6, 40, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 1, NZ,   32'd52, 14, 4, 2, 7, 40, 1, 0, 0);
    vecs[16] = mk(0, 1, 0, 0, 0, NZ,   32'd56, 15, 5, 2, 7, 40, 0, 1, 0);
    vecs[17] = mk(1, 1, 0, 1, 1, 32'd0, 32'd60, 15, 5, 2, 7, 40, 0, 1, 0);

    do_reset();
    e = '0;
    chk_a("reset", e);

    // Full program run on the default instance, scoreboarded row by row.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].branch, vecs[i].flush, vecs[i].wbv,
            vecs[i].instr, vecs[i].pc);
      sb_q.push_back(vecs[i].exp);
      tick();
      chk_a($sformatf("row%0d", i), sb_q.pop_front());
    end
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset mid-drain clears everything, then counting restarts from zero.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NZ, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, NZ, 32'(4 * i));
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd12);
    tick();
    tick();
    chk("pre_rst cycle", 64'(a_cyc), 64'd5);
    chk("pre_rst stall", 64'(a_stl), 64'd5);
    chk("pre_rst end_pc", 64'(a_epc), 64'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = '0;
    chk_a("drain_rst", e);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NZ, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NZ, 32'd4);
    tick();
    tick();
    chk("restart cycle", 64'(a_cyc), 64'd2);
    chk("restart run", 64'(a_run), 64'd1);

    // Cycle limit of 8 with no end-of-program fetch.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NZ, 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NZ, 32'(4 * i));
      tick();
      if (i == 6) chk("lim7 done", 64'(b_done), 64'd0);
    end
    chk("lim cycle", 64'(b_cyc), 64'd8);
    chk("lim done", 64'(b_done), 64'd1);
    chk("lim run", 64'(b_run), 64'd0);
    chk("lim cause", 64'(b_cause), 64'd1);
    tick();
    chk("lim frozen", 64'(b_cyc), 64'd8);

    // Limit wins over the zero fetch landing on counted cycle 8.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NZ, 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i == 7) ? 32'd0 : NZ, 32'(4 * i));
      tick();
    end
    chk("limeop cycle", 64'(b_cyc), 64'd8);
    chk("limeop done", 64'(b_done), 64'd1);
    chk("limeop cause", 64'(b_cause), 64'd1);
    chk("limeop end_pc", 64'(b_epc), 64'h1c);

    // 4-bit counters saturate at 15.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NZ, 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NZ, 32'(4 * i));
      tick();
      if (i == 13) chk("sat14 cycle", 64'(c_cyc), 64'd14);
      if (i == 14) chk("sat15 flush", 64'(c_fls), 64'd15);
    end
    chk("sat cycle", 64'(c_cyc), 64'd15);
    chk("sat flush", 64'(c_fls), 64'd15);
    chk("sat stall", 64'(c_stl), 64'd0);
    chk("sat run", 64'(c_run), 64'd1);
    chk("sat done", 64'(c_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
Hardware run monitor that sits directly downstream of the pipelined CPU core and consumes its hazard, flush, fetch and writeback signals. It counts cycles, load-use stalls, flushes and retired instructions. It detects end-of-program, which is fetch of the all-zero padding word, and asserts done once the pipeline has drained. The simulation top then stops on done_o and reads the counters directly, instead of counting stalls and flushes itself with a fixed cycle limit.

Parameters:
CNT_W, 32, width of every counter output
DRAIN_CYCLES, 4, cycles spent in DRAIN after end-of-program fetch (IF→WB depth minus 1)
MAX_CYCLES, 64, hard cycle limit on counted cycles; 0 disables the limit

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
start_i  in  1  CPU start; level, sampled only in IDLE
stall_i  in  1  hazard-detection stall request
branch_i  in  1  ID-stage branch decode; a stall with branch_i=1 is not a load-use stall
flush_i  in  1  IF flush (taken branch)
wb_valid_i  in  1  MEM/WB stage holds a real (non-bubble) instruction this cycle
if_instr_i  in  32  instruction word currently fetched in IF
pc_i  in  32  current PC
cycle_cnt_o  out  CNT_W  counted cycles
stall_cnt_o  out  CNT_W  load-use stall cycles
flush_cnt_o  out  CNT_W  flush cycles
retire_cnt_o  out  CNT_W  retired instructions
end_pc_o  out  32  PC at which the end-of-program word was fetched
running_o  out  1  state is RUN or DRAIN
done_o  out  1  state is DONE
done_cause_o  out  1  0 = end-of-program, 1 = MAX_CYCLES limit

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; all counters 0; end_pc_o 0; running_o 0; done_o 0; done_cause_o 0. Reset has priority over everything, including mid-RUN, mid-DRAIN and DONE.
- All outputs are registered. Counter values reflect events up to and including the previous cycle.
- States:
  - IDLE: nothing counted. start_i=1 at an edge moves to RUN. The IDLE cycle itself is not counted.
  - RUN: counts every cycle. If if_instr_i==32'h0 this cycle, capture pc_i into end_pc_o, load the drain counter with DRAIN_CYCLES, and move to DRAIN. That fetch cycle is itself counted. start_i is ignored.
  - DRAIN: counts every cycle; the drain counter decrements each cycle. When it reaches 1, move to DONE with done_cause_o=0. Further zero fetches are ignored. If DRAIN_CYCLES=0, RUN goes directly to DONE.
  - DONE: all counters frozen. done_o=1 until reset. Inputs are ignored.
- Event rules, applied in counted cycles (RUN/DRAIN) only:
  - cycle +1 every cycle.
  - stall +1 iff stall_i & ~branch_i.
  - flush +1 iff flush_i.
  - retire +1 iff wb_valid_i.
  - Simultaneous events each count independently. Example: stall and flush in the same cycle both increment.
- Limit: when MAX_CYCLES≠0 and a cycle increment makes cycle_cnt equal to MAX_CYCLES, the next state is DONE with done_cause_o=1. The limit takes priority over the RUN→DRAIN transition and over drain completion in the same cycle.
- Saturation: every counter holds at 2^CNT_W−1 and never wraps. MAX_CYCLES > 2^CNT_W−1 behaves as disabled.
- X-safety: inputs are only sampled in counted states, so X on stall_i/flush_i in IDLE must not corrupt the counters.

Decomposition:
- Shared CPU package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3)
  - the END_OF_PROGRAM_WORD constant (32'h0)
  - DONE_CAUSE_EOP / DONE_CAUSE_LIMIT constants
- One sub-module: sat_counter, parameterised on width, with inputs clk, sync reset, en and inc, and output count with saturation. It is instantiated four times. The FSM and drain counter live in the top.

Test Plan:
1. Reset, start_i=1 at cycle 0, ten nonzero fetches, then 32'h0 at PC=40 → running_o 1 for 15 cycles; then done_o=1, cycle_cnt=15, end_pc_o=40, done_cause_o=0.
2. In RUN: stall_i=1 with branch_i=1 for 2 cycles, then stall_i=1 with branch_i=0 for 3 cycles → stall_cnt=3.
3. stall_i=1, branch_i=0 and flush_i=1 in the same single cycle, with wb_valid_i=1 → stall_cnt, flush_cnt and retire_cnt each +1.
4. MAX_CYCLES=8, no zero fetch → DONE after exactly 8 counted cycles, cycle_cnt=8, done_cause_o=1. Repeat with the zero fetch on counted cycle 8 → done_cause_o=1 and end_pc_o still captured.
5. rst_i=1 for one cycle during DRAIN with all counters nonzero → next cycle: IDLE, all counters 0, done_o=0; a new start_i restarts counting from 0.
6. CNT_W=4, MAX_CYCLES=0, 20 nonzero fetches with flush_i=1 every cycle → cycle_cnt=15 and flush_cnt=15, held with no wrap.
